// File: rtl/out_reg_write_sequencer.sv
// Sequences writes into a 16 x 8-bit output register bank and drives its clear strobe and output-enable mask.
// Latency: WRITE takes SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, OE_SET/reserved take 1, CLEAR takes STROBE_CYC; done follows.
// Backpressure: req_ready is high only in IDLE (including the done cycle); the requester holds its command until accepted.
module out_reg_write_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        CLR_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic [7:0]  data_bus,
    output logic [15:0] sel,
    output logic [15:0] oe,
    output logic        reg_clr,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_APPLY,
        ST_CLEAR
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_OE_SET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Phase counter reload values: each phase lasts *_CYC cycles, exiting when the counter reaches 0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [1:0]       op_q;
    logic [3:0]       addr_q;
    logic             oe_bit_q;

    // Sequencer FSM; every output is a flop so sel/reg_clr edges are glitch-free register clocks.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            op_q      <= OP_WRITE;
            addr_q    <= '0;
            oe_bit_q  <= 1'b0;
            req_ready <= 1'b1;
            data_bus  <= '0;
            sel       <= '0;
            oe        <= '0;
            reg_clr   <= 1'b1;   // bank is held cleared until the first edge after release
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    reg_clr <= 1'b0;
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        oe_bit_q  <= req_data[0];
                        req_ready <= 1'b0;
                        case (req_op)
                            OP_WRITE: begin
                                state     <= ST_SETUP;
                                data_bus  <= req_data;
                                phase_cnt <= SETUP_LD;
                            end
                            OP_CLEAR: begin
                                state     <= ST_CLEAR;
                                reg_clr   <= 1'b1;
                                data_bus  <= '0;
                                phase_cnt <= STROBE_LD;
                            end
                            default: begin
                                state <= ST_APPLY;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_STROBE;
                        sel       <= 16'h0001 << addr_q;
                        phase_cnt <= STROBE_LD;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_HOLD;
                        sel       <= '0;
                        phase_cnt <= HOLD_LD;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (op_q == OP_OE_SET) begin
                        oe[addr_q] <= oe_bit_q;
                    end
                    err       <= (op_q == OP_RSVD);
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    done      <= 1'b1;
                end
                ST_CLEAR: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_IDLE;
                        reg_clr   <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sel       <= '0;
                    reg_clr   <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_reg_write_sequencer.sv
// Bench for out_reg_write_sequencer: default-timing instance plus a SETUP=3/STROBE=1/HOLD=2 instance.
// Inputs are driven and outputs sampled on the falling edge; a command-level model predicts every busy cycle.
// Random command streams with optional back-to-back issue exercise the handshake.
module tb_out_reg_write_sequencer;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic        CLK = 1'b0;
    logic        CLR_n = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_addr = 4'h0;
    logic [7:0]  req_data = 8'h00;
    logic [7:0]  data_bus;
    logic [15:0] sel;
    logic [15:0] oe;
    logic        reg_clr;
    logic        done;
    logic        err;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_op = 2'b00;
    logic [3:0]  b_addr = 4'h0;
    logic [7:0]  b_data = 8'h00;
    logic [7:0]  b_bus;
    logic [15:0] b_sel;
    logic [15:0] b_oe;
    logic        b_clr;
    logic        b_done;
    logic        b_err;

    int checks = 0;
    int errors = 0;

    // Command-level model state
    logic [15:0] m_oe  = 16'h0;
    logic [7:0]  m_bus = 8'h0;

    always #5 CLK = ~CLK;

    out_reg_write_sequencer #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .CNT_W(4)) dut (
        .CLK(CLK), .CLR_n(CLR_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .data_bus(data_bus), .sel(sel), .oe(oe),
        .reg_clr(reg_clr), .done(done), .err(err)
    );

    out_reg_write_sequencer #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .CNT_W(4)) dut_b (
        .CLK(CLK), .CLR_n(CLR_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_addr(b_addr), .req_data(b_data),
        .data_bus(b_bus), .sel(b_sel), .oe(b_oe),
        .reg_clr(b_clr), .done(b_done), .err(b_err)
    );

    // Issue one command at the current falling edge and check every busy cycle plus the done cycle.
    // Returns at the done-cycle falling edge so a following call issues back-to-back.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d, input string tag);
        int len;
        logic [15:0] exp_sel;
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s ready_before_issue: req_ready=%b required 1", tag, req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(negedge CLK);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 4'($urandom);
        req_data  = 8'($urandom);
        len = (op == 2'b00) ? (S + T + H) : (op == 2'b10) ? T : 1;
        if (op == 2'b00) m_bus = d;
        if (op == 2'b10) m_bus = 8'h00;
        for (int i = 1; i <= len; i++) begin
            exp_sel = (op == 2'b00 && i > S && i <= S + T) ? (16'h0001 << a) : 16'h0000;
            checks++;
            if ({req_ready, done, err, sel, reg_clr, data_bus, oe} !==
                {1'b0, 1'b0, 1'b0, exp_sel, (op == 2'b10), m_bus, m_oe}) begin
                errors++;
                $display("FAIL %s busy_cyc%0d: ready=%b done=%b err=%b sel=%h clr=%b bus=%h oe=%h required ready=0 done=0 err=0 sel=%h clr=%b bus=%h oe=%h",
                         tag, i, req_ready, done, err, sel, reg_clr, data_bus, oe,
                         exp_sel, (op == 2'b10), m_bus, m_oe);
            end
            @(negedge CLK);
        end
        if (op == 2'b01) m_oe[a] = d[0];
        checks++;
        if ({req_ready, done, err, sel, reg_clr, data_bus, oe} !==
            {1'b1, 1'b1, (op == 2'b11), 16'h0000, 1'b0, m_bus, m_oe}) begin
            errors++;
            $display("FAIL %s done_cyc: ready=%b done=%b err=%b sel=%h clr=%b bus=%h oe=%h required ready=1 done=1 err=%b sel=0000 clr=0 bus=%h oe=%h",
                     tag, req_ready, done, err, sel, reg_clr, data_bus, oe, (op == 2'b11), m_bus, m_oe);
        end
    endtask

    // Idle cycles: nothing may move and done/err must not repeat.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checks++;
            if ({req_ready, done, err, sel, reg_clr, data_bus, oe} !==
                {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, m_bus, m_oe}) begin
                errors++;
                $display("FAIL %s idle_cyc%0d: ready=%b done=%b err=%b sel=%h clr=%b bus=%h oe=%h required ready=1 done=0 err=0 sel=0000 clr=0 bus=%h oe=%h",
                         tag, i, req_ready, done, err, sel, reg_clr, data_bus, oe, m_bus, m_oe);
            end
        end
    endtask

    task automatic test_reset();
        #2 CLR_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, done, err, sel, oe, reg_clr, data_bus} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 8'h0}) begin
            errors++;
            $display("FAIL reset_values: ready=%b done=%b err=%b sel=%h oe=%h clr=%b bus=%h required 1 0 0 0000 0000 1 00",
                     req_ready, done, err, sel, oe, reg_clr, data_bus);
        end
        repeat (3) @(negedge CLK);
        CLR_n = 1'b1;
        #1;
        checks++;
        if (reg_clr !== 1'b1 || b_clr !== 1'b1) begin
            errors++;
            $display("FAIL reset_clr_held: reg_clr=%b b_clr=%b required 1 1", reg_clr, b_clr);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (reg_clr !== 1'b0 || b_clr !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_clr_release: reg_clr=%b b_clr=%b ready=%b required 0 0 1", reg_clr, b_clr, req_ready);
        end
        m_oe  = 16'h0;
        m_bus = 8'h0;
        @(negedge CLK);
    endtask

    task automatic test_write_basic();
        do_cmd(2'b00, 4'd5, 8'hA7, "write_a5");
        idle(2, "write_a5");
    endtask

    task automatic test_oe_set();
        do_cmd(2'b01, 4'd3, 8'h01, "oe_3_on");
        checks++;
        if (oe !== 16'h0008) begin errors++; $display("FAIL oe_step1: oe=%h required 0008", oe); end
        do_cmd(2'b01, 4'd12, 8'h01, "oe_12_on");
        checks++;
        if (oe !== 16'h1008) begin errors++; $display("FAIL oe_step2: oe=%h required 1008", oe); end
        do_cmd(2'b01, 4'd3, 8'h00, "oe_3_off");
        checks++;
        if (oe !== 16'h1000) begin errors++; $display("FAIL oe_step3: oe=%h required 1000", oe); end
        idle(1, "oe");
    endtask

    task automatic test_back_to_back();
        do_cmd(2'b00, 4'd15, 8'h3C, "b2b_first");
        do_cmd(2'b00, 4'd0, 8'hFF, "b2b_second");
        idle(1, "b2b");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) do_cmd(2'b01, 4'(i), 8'h01, "clr_prep");
        do_cmd(2'b01, 4'd12, 8'h00, "clr_prep12");
        checks++;
        if (oe !== 16'h00FF) begin errors++; $display("FAIL clear_prep_oe: oe=%h required 00ff", oe); end
        do_cmd(2'b10, 4'($urandom), 8'($urandom), "clear");
        checks++;
        if (oe !== 16'h00FF) begin errors++; $display("FAIL clear_keeps_oe: oe=%h required 00ff", oe); end
        idle(1, "clear");
    endtask

    task automatic test_reserved();
        do_cmd(2'b11, 4'($urandom), 8'($urandom), "reserved");
        idle(1, "reserved");
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 4'd7;
        req_data  = 8'($urandom);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (sel !== 16'h0080) begin errors++; $display("FAIL midrst_strobe: sel=%h required 0080", sel); end
        #2 CLR_n = 1'b0;
        #1;
        checks++;
        if ({sel, oe, done, reg_clr, req_ready} !== {16'h0, 16'h0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midrst_abort: sel=%h oe=%h done=%b clr=%b ready=%b required 0000 0000 0 1 1",
                     sel, oe, done, reg_clr, req_ready);
        end
        @(negedge CLK);
        CLR_n = 1'b1;
        m_oe  = 16'h0;
        m_bus = 8'h0;
        #1;
        checks++;
        if (reg_clr !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release: clr=%b ready=%b required 1 1", reg_clr, req_ready);
        end
        idle(3, "midrst_after");
    endtask

    task automatic test_custom_timing();
        int n;
        logic [3:0]  a;
        logic [7:0]  d;
        logic [15:0] exp_sel;
        a = 4'($urandom);
        d = 8'($urandom);
        b_valid = 1'b1;
        b_op    = 2'b00;
        b_addr  = a;
        b_data  = d;
        @(negedge CLK);
        b_valid = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 20) begin
            exp_sel = (n + 1 == 4) ? (16'h0001 << a) : 16'h0000;
            checks++;
            if ({b_ready, b_sel, b_bus, b_clr} !== {1'b0, exp_sel, d, 1'b0}) begin
                errors++;
                $display("FAIL custom_busy_cyc%0d: ready=%b sel=%h bus=%h clr=%b required 0 %h %h 0",
                         n + 1, b_ready, b_sel, b_bus, b_clr, exp_sel, d);
            end
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n != 6 || b_done !== 1'b1 || b_err !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL custom_span: busy=%0d done=%b err=%b ready=%b required 6 1 0 1", n, b_done, b_err, b_ready);
        end
        @(negedge CLK);
        checks++;
        if (b_done !== 1'b0) begin errors++; $display("FAIL custom_done_pulse: done=%b required 0", b_done); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            do_cmd(op, 4'($urandom), 8'($urandom), "random");
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), "random");
        end
        idle(1, "random_end");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_oe_set();
        test_back_to_back();
        test_clear();
        test_reserved();
        test_reset_mid();
        test_custom_timing();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/out_reg_write_sequencer.md
Name: out_reg_write_sequencer

Overview:
- Controller that sequences writes into the bank of 16 edge-clocked 8-bit output registers and manages their 16 tri-state output enables.
- Accepts commands over a valid/ready handshake and drives the shared 8-bit data bus. Generates a glitch-free one-hot select strobe (the register's clock edge) with programmable setup, strobe and hold phases.
- Also owns the bank-wide register clear and the per-buffer output-enable mask.
- Sits between the host command decoder and the output register/buffer bank.

Parameters:
- SETUP_CYC, 1, cycles data_bus is stable before the select strobe rises (>=1)
- STROBE_CYC, 2, cycles the select strobe (or reg_clr for CLEAR) stays high (>=1)
- HOLD_CYC, 1, cycles data_bus is held after the strobe falls (>=1)
- CNT_W, 4, phase counter width; every *_CYC must be <= 2**CNT_W-1

Ports:
- CLK  in  1  clock, rising edge
- CLR_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  command valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 WRITE, 01 OE_SET, 10 CLEAR, 11 reserved
- req_addr  in  4  target register/buffer index 0..15
- req_data  in  8  write data; bit0 = enable value for OE_SET
- data_bus  out  8  shared data to all registers
- sel  out  16  one-hot register strobes; all registered, no combinational path
- oe  out  16  buffer output-enable mask
- reg_clr  out  1  bank clear, active-high
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for a reserved op

Behaviour:
- Reset (CLR_n low), effective immediately:
  - state=IDLE; data_bus=0, sel=0, oe=0 (all buffers high-Z), done=0, err=0.
  - reg_clr=1. It stays 1 until the first CLK edge after CLR_n rises, then goes 0, so the bank is always cleared out of reset.
- Acceptance: a command is accepted on an edge where req_valid & req_ready. op/addr/data are latched; inputs are ignored afterwards.
- FSM states: IDLE, SETUP, STROBE, HOLD, APPLY, CLEAR.
- WRITE (acceptance at edge k, S/T/H = SETUP_CYC/STROBE_CYC/HOLD_CYC):
  - SETUP for S cycles: data_bus=latched data, sel=0.
  - STROBE for T cycles: sel[addr]=1, data_bus unchanged.
  - HOLD for H cycles: sel=0, data_bus unchanged.
  - Then IDLE, with done=1 for exactly that first IDLE cycle.
  - Busy span = S+T+H cycles (default 4). data_bus keeps its last value in IDLE.
- OE_SET: one APPLY cycle in which oe[addr] <= req_data[0]; other oe bits unchanged. Then IDLE with done=1.
- CLEAR: CLEAR state for T cycles with reg_clr=1, sel=0, data_bus=0. oe is unaffected. Then IDLE with done=1.
- Reserved op 11: one APPLY cycle with no side effects, then IDLE with done=1 and err=1.
- Back-to-back: req_ready is high during the done cycle, so a new command may be accepted in that same cycle. No idle bubble is required.
- Exactly one sel bit may be high at any time. sel and reg_clr are never high together.
- Phase counter: loads *_CYC-1 on each state entry, decrements, and the state exits at 0. The counter does not wrap.
- Reset mid-operation: sel and done drop to 0 immediately. The aborted command never produces done, and oe is zeroed.
- req_valid high in a non-IDLE state is not accepted, and the command is not lost by the sequencer: the requester holds it.

Test Plan:
- Reset release, then WRITE addr=5 data=0xA7 -> reg_clr=1 until the first edge after release. data_bus=0xA7 one cycle before sel[5] rises. sel=0x0020 for 2 cycles, then 1 hold cycle, then done pulse. Total 4 busy cycles.
- OE_SET addr=3 data=0x01, then addr=12 data=0x01, then addr=3 data=0x00 -> oe goes 0x0008, 0x1008, 0x1000; done after each single APPLY cycle.
- WRITE addr=15 data=0x3C issued back-to-back with WRITE addr=0 data=0xFF (second accepted in the done cycle) -> sel shows 0x8000 then 0x0001 with no overlap. data_bus changes only after HOLD.
- CLEAR with oe=0x00FF -> reg_clr=1 for 2 cycles, sel=0, data_bus=0, oe still 0x00FF, then done.
- CLR_n asserted during the STROBE of WRITE addr=7 -> sel=0 and oe=0 immediately, no done. After release, reg_clr=1 for 1 cycle and req_ready=1.
- Reserved op 11 -> done and err both high for one cycle; sel, oe and reg_clr unchanged. With SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, a WRITE shows a 6-cycle busy span.
